rr_interval_classifier: RTL and testbench

RR_INTERVAL_CLASSIFIER -- requirements
Module: rr_interval_classifier

---
 rtl/rr_interval_classifier.sv | 196 +++++++++++++++++++
 tb/tb_rr_interval_classifier.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_interval_classifier.sv
// Beat-to-beat (RR) interval measurement from a raw heartbeat pulse. It classifies
// the rate, flags irregular intervals and asystole, and keeps a running average.
module rr_interval_classifier #(
    parameter int              RR_W         = 12,
    parameter int              CNT_W        = 8,
    parameter int              AVG_LOG2     = 2,
    parameter logic [RR_W-1:0] TACHY_MS     = RR_W'(600),
    parameter logic [RR_W-1:0] BRADY_MS     = RR_W'(1000),
    parameter logic [RR_W-1:0] REFRACT_MS   = RR_W'(200),
    parameter logic [RR_W-1:0] IRR_DELTA_MS = RR_W'(150),
    parameter logic [RR_W-1:0] TIMEOUT_MS   = RR_W'(3000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_ms,
    input  logic             pulse_in,
    input  logic             clear_cnt,
    output logic [RR_W-1:0]  rr_ms,
    output logic             rr_valid,
    output logic [1:0]       class_code,
    output logic             irregular,
    output logic             asystole,
    output logic [RR_W-1:0]  avg_ms,
    output logic             avg_valid,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] tachy_count,
    output logic [CNT_W-1:0] brady_count,
    output logic [CNT_W-1:0] irr_count
);
    localparam int SUM_W = RR_W + AVG_LOG2;
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam logic [RR_W-1:0]     RR_MAX    = '1;
    localparam logic [AVG_LOG2-1:0] FILL_LAST = '1;

    typedef enum logic {WAIT_FIRST = 1'b0, MEASURE = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [RR_W:0] abs_diff(input logic [RR_W-1:0] a, input logic [RR_W-1:0] b);
        logic signed [RR_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    function automatic logic [1:0] classify(input logic [RR_W-1:0] rr);
        if (rr < TACHY_MS)      return 2'b01;
        else if (rr > BRADY_MS) return 2'b10;
        else                    return 2'b00;
    endfunction

    logic [2:0]      sync_q;
    state_t          state_q, state_d;
    logic [RR_W-1:0] ms_cnt_q, ms_cnt_d;
    logic            rise, beat_acc, meas_beat, timeout;

    logic              rr_valid_q, irr_q, asys_q, prev_vld_q, avg_vld_q;
    logic [RR_W-1:0]   rr_ms_q, prev_rr_q, avg_ms_q;
    logic [1:0]        class_q;
    logic [RR_W-1:0]   avg_buf_q [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr_q, fill_q;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  beat_cnt_q, tachy_cnt_q, brady_cnt_q, irr_cnt_q;
    logic [RR_W:0]     dev;
    logic              irr_now, is_tachy, is_brady;

    // Input synchroniser; the third flop only provides the previous value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], pulse_in};
    end
    assign rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_FIRST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FIRST: if (beat_acc) state_d = MEASURE;
            MEASURE:    if (timeout)  state_d = WAIT_FIRST;
            default:    state_d = WAIT_FIRST;
        endcase
    end

    // The refractory check only applies once an interval is running; a beat beats a timeout
    always_comb begin
        beat_acc  = 1'b0;
        meas_beat = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            WAIT_FIRST: beat_acc = rise;
            MEASURE: begin
                beat_acc  = rise && (ms_cnt_q >= REFRACT_MS);
                meas_beat = beat_acc;
                timeout   = !beat_acc && (ms_cnt_q >= TIMEOUT_MS);
            end
            default: ;
        endcase
    end

    always_comb begin
        ms_cnt_d = ms_cnt_q;
        if (beat_acc)                             ms_cnt_d = '0;
        else if (tick_ms && (ms_cnt_q != RR_MAX)) ms_cnt_d = ms_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ms_cnt_q <= '0;
        else        ms_cnt_q <= ms_cnt_d;
    end

    assign dev      = abs_diff(ms_cnt_q, prev_rr_q);
    assign irr_now  = prev_vld_q && (dev > {1'b0, IRR_DELTA_MS});
    assign is_tachy = ms_cnt_q < TACHY_MS;
    assign is_brady = ms_cnt_q > BRADY_MS;
    assign sum_d    = sum_q - SUM_W'(avg_buf_q[wr_ptr_q]) + SUM_W'(ms_cnt_q);

    // Result stage: all interval outputs update together with rr_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_valid_q <= 1'b0;
            rr_ms_q    <= '0;
            class_q    <= 2'b00;
            irr_q      <= 1'b0;
            asys_q     <= 1'b0;
            prev_rr_q  <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            rr_valid_q <= meas_beat;
            if (meas_beat) begin
                rr_ms_q    <= ms_cnt_q;
                class_q    <= classify(ms_cnt_q);
                irr_q      <= irr_now;
                prev_rr_q  <= ms_cnt_q;
                prev_vld_q <= 1'b1;
            end else if (timeout) begin
                class_q <= 2'b11;
            end
            if (timeout)       asys_q <= 1'b1;
            else if (beat_acc) asys_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) avg_buf_q[i] <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            avg_ms_q  <= '0;
            avg_vld_q <= 1'b0;
        end else if (meas_beat) begin
            avg_buf_q[wr_ptr_q] <= ms_cnt_q;
            wr_ptr_q <= wr_ptr_q + 1'b1;
            sum_q    <= sum_d;
            avg_ms_q <= sum_d[SUM_W-1:AVG_LOG2];
            if (fill_q == FILL_LAST) avg_vld_q <= 1'b1;
            else                     fill_q    <= fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            tachy_cnt_q <= '0;
            brady_cnt_q <= '0;
            irr_cnt_q   <= '0;
        end else if (clear_cnt) begin
            beat_cnt_q  <= '0;
            tachy_cnt_q <= '0;
            brady_cnt_q <= '0;
            irr_cnt_q   <= '0;
        end else begin
            if (beat_acc)              beat_cnt_q  <= sat_inc(beat_cnt_q);
            if (meas_beat && is_tachy) tachy_cnt_q <= sat_inc(tachy_cnt_q);
            if (meas_beat && is_brady) brady_cnt_q <= sat_inc(brady_cnt_q);
            if (meas_beat && irr_now)  irr_cnt_q   <= sat_inc(irr_cnt_q);
        end
    end

    assign rr_ms       = rr_ms_q;
    assign rr_valid    = rr_valid_q;
    assign class_code  = class_q;
    assign irregular   = irr_q;
    assign asystole    = asys_q;
    assign avg_ms      = avg_ms_q;
    assign avg_valid   = avg_vld_q;
    assign beat_count  = beat_cnt_q;
    assign tachy_count = tachy_cnt_q;
    assign brady_count = brady_cnt_q;
    assign irr_count   = irr_cnt_q;
endmodule

// File: tb/tb_rr_interval_classifier.sv
// Directed bench for rr_interval_classifier: table of intervals plus corner sequences.
module tb_rr_interval_classifier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_ms = 1'b0;
    logic        pulse_in = 1'b0;
    logic        clear_cnt = 1'b0;
    logic [11:0] rr_ms, avg_ms;
    logic        rr_valid, irregular, asystole, avg_valid;
    logic [1:0]  class_code;
    logic [7:0]  beat_count, tachy_count, brady_count, irr_count;

    rr_interval_classifier dut (
        .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .pulse_in(pulse_in),
        .clear_cnt(clear_cnt), .rr_ms(rr_ms), .rr_valid(rr_valid),
        .class_code(class_code), .irregular(irregular), .asystole(asystole),
        .avg_ms(avg_ms), .avg_valid(avg_valid), .beat_count(beat_count),
        .tachy_count(tachy_count), .brady_count(brady_count), .irr_count(irr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int nvalid = 0;
    int cap_rr, cap_cls, cap_irr, cap_avgv, cap_avg;

    always @(negedge clk) begin
        if (rst_n && rr_valid) begin
            nvalid   <= nvalid + 1;
            cap_rr   <= int'(rr_ms);
            cap_cls  <= int'(class_code);
            cap_irr  <= int'(irregular);
            cap_avgv <= int'(avg_valid);
            cap_avg  <= int'(avg_ms);
        end
    end

    typedef struct {
        int rr;
        int cls;
        int irr;
        int avgv;
        int avg;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat();
        pulse_in = 1'b1;
        repeat (4) cyc();
        pulse_in = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic ms(input int n);
        tick_ms = 1'b1;
        repeat (n) cyc();
        tick_ms = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pulse_in = 1'b0;
        tick_ms = 1'b0;
        clear_cnt = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int nv0;
        vecs[0] = '{rr: 800,  cls: 0, irr: 0, avgv: 0, avg: 200};
        vecs[1] = '{rr: 800,  cls: 0, irr: 0, avgv: 0, avg: 400};
        vecs[2] = '{rr: 800,  cls: 0, irr: 0, avgv: 0, avg: 600};
        vecs[3] = '{rr: 1200, cls: 2, irr: 1, avgv: 1, avg: 900};
        vecs[4] = '{rr: 599,  cls: 1, irr: 1, avgv: 1, avg: 849};
        vecs[5] = '{rr: 600,  cls: 0, irr: 0, avgv: 1, avg: 799};
        vecs[6] = '{rr: 1000, cls: 0, irr: 1, avgv: 1, avg: 849};
        vecs[7] = '{rr: 1001, cls: 2, irr: 0, avgv: 1, avg: 800};
        vecs[8] = '{rr: 750,  cls: 0, irr: 1, avgv: 1, avg: 837};
        vecs[9] = '{rr: 900,  cls: 0, irr: 0, avgv: 1, avg: 912};

        // Reset values, sampled while reset is held
        repeat (2) cyc();
        chk("reset rr_valid", int'(rr_valid), 0);
        chk("reset rr_ms", int'(rr_ms), 0);
        chk("reset class", int'(class_code), 0);
        chk("reset asystole", int'(asystole), 0);
        chk("reset avg_valid", int'(avg_valid), 0);
        chk("reset beat_count", int'(beat_count), 0);
        rst_n = 1'b1;
        cyc();

        // Two beats 800 ms apart
        nv0 = nvalid;
        beat();
        chk("arm no rr_valid", nvalid - nv0, 0);
        chk("arm beat_count", int'(beat_count), 1);
        ms(800);
        beat();
        chk("basic rr_valid count", nvalid - nv0, 1);
        chk("basic rr_ms", cap_rr, 800);
        chk("basic class", cap_cls, 0);
        chk("basic beat_count", int'(beat_count), 2);

        // Table of intervals: classification, irregularity, average
        do_reset();
        beat();
        for (int i = 0; i < 10; i++) begin
            nv0 = nvalid;
            ms(vecs[i].rr);
            beat();
            chk($sformatf("vec%0d rr_valid count", i), nvalid - nv0, 1);
            chk($sformatf("vec%0d rr_ms", i), cap_rr, vecs[i].rr);
            chk($sformatf("vec%0d class", i), cap_cls, vecs[i].cls);
            chk($sformatf("vec%0d irregular", i), cap_irr, vecs[i].irr);
            chk($sformatf("vec%0d avg_valid", i), cap_avgv, vecs[i].avgv);
            chk($sformatf("vec%0d avg_ms", i), cap_avg, vecs[i].avg);
        end
        chk("table beat_count", int'(beat_count), 11);
        chk("table tachy_count", int'(tachy_count), 1);
        chk("table brady_count", int'(brady_count), 2);
        chk("table irr_count", int'(irr_count), 4);

        // Refractory rejection
        do_reset();
        beat();
        ms(150);
        nv0 = nvalid;
        beat();
        chk("refract no rr_valid", nvalid - nv0, 0);
        chk("refract beat_count", int'(beat_count), 1);
        ms(550);
        beat();
        chk("refract rr_valid count", nvalid - nv0, 1);
        chk("refract rr_ms", cap_rr, 700);

        // Asystole timeout and recovery
        do_reset();
        beat();
        ms(2999);
        cyc();
        chk("pre-timeout asystole", int'(asystole), 0);
        nv0 = nvalid;
        ms(1);
        repeat (2) cyc();
        chk("timeout asystole", int'(asystole), 1);
        chk("timeout class", int'(class_code), 3);
        chk("timeout no rr_valid", nvalid - nv0, 0);
        beat();
        chk("recover asystole", int'(asystole), 0);
        chk("recover no rr_valid", nvalid - nv0, 0);
        chk("recover beat_count", int'(beat_count), 2);
        ms(500);
        beat();
        chk("post-recover rr_ms", cap_rr, 500);
        chk("post-recover class", cap_cls, 1);

        // clear_cnt on the same edge as a tachy interval completes
        do_reset();
        beat();
        ms(300);
        beat();
        chk("pre-clear tachy_count", int'(tachy_count), 1);
        ms(400);
        nv0 = nvalid;
        pulse_in = 1'b1;
        cyc();
        cyc();
        clear_cnt = 1'b1;
        cyc();
        clear_cnt = 1'b0;
        pulse_in = 1'b0;
        repeat (5) cyc();
        chk("clear rr_valid count", nvalid - nv0, 1);
        chk("clear rr_ms", cap_rr, 400);
        chk("clear tachy_count", int'(tachy_count), 0);
        chk("clear beat_count", int'(beat_count), 0);

        // Reset mid-interval discards the running interval
        ms(300);
        do_reset();
        nv0 = nvalid;
        beat();
        chk("post-reset arm no rr_valid", nvalid - nv0, 0);
        ms(700);
        beat();
        chk("post-reset rr_valid count", nvalid - nv0, 1);
        chk("post-reset rr_ms", cap_rr, 700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
